// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the ALU/load sources and the register-file arbiter.
// The master modport belongs to the source side, and the slave modport belongs to the arbiter.
interface rf_wb_arbiter_if #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int CNT_W = 16
);
    logic             wb_stall;
    logic             alu_valid;
    logic [AW-1:0]    alu_addr;
    logic [DW-1:0]    alu_data;
    logic             alu_ready;
    logic             mem_valid;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_data;
    logic             mem_ready;
    logic [NREGS-1:0] rf_en;
    logic [DW-1:0]    rf_wdata;
    logic [AW-1:0]    rf_wr_addr;
    logic             rf_wr_valid;
    logic [CNT_W-1:0] conflict_cnt;

    modport master (
        output wb_stall, alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        input  alu_ready, mem_ready, rf_en, rf_wdata, rf_wr_addr, rf_wr_valid, conflict_cnt
    );

    modport slave (
        input  wb_stall, alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
        output alu_ready, mem_ready, rf_en, rf_wdata, rf_wr_addr, rf_wr_valid, conflict_cnt
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter that shares the register-file write port between ALU and load writebacks.
// The winning write is registered and then driven as one-hot enables plus a broadcast data bus.
module rf_wb_arbiter #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    rf_wb_arbiter_if.slave wb
);
    logic             r_prio;
    logic [NREGS-1:0] r_en;
    logic [DW-1:0]    r_wdata;
    logic [AW-1:0]    r_wr_addr;
    logic             r_wr_valid;
    logic [CNT_W-1:0] r_cnt;

    logic             w_alu_grant;
    logic             w_mem_grant;
    logic             w_xfer;
    logic             w_conflict;
    logic [AW-1:0]    w_sel_addr;
    logic [DW-1:0]    w_sel_data;
    logic [NREGS-1:0] w_dec;

    // The grant is based only on the valids, prio and stall, so the ready signals never loop back into valid.
    assign w_conflict  = wb.alu_valid & wb.mem_valid & ~wb.wb_stall;
    assign w_alu_grant = ~wb.wb_stall & wb.alu_valid & (~wb.mem_valid | ~r_prio);
    assign w_mem_grant = ~wb.wb_stall & wb.mem_valid & (~wb.alu_valid |  r_prio);
    assign w_xfer      = w_alu_grant | w_mem_grant;

    assign w_sel_addr  = w_mem_grant ? wb.mem_addr : wb.alu_addr;
    assign w_sel_data  = w_mem_grant ? wb.mem_data : wb.alu_data;

    // Register 0 never gets an enable bit, and addresses at or above NREGS match no bit, so those writes are dropped.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_dec
            if (gi == 0) begin : g_r0
                assign w_dec[gi] = 1'b0;
            end else begin : g_rn
                assign w_dec[gi] = (w_sel_addr == AW'(gi));
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio     <= 1'b0;
            r_en       <= '0;
            r_wdata    <= '0;
            r_wr_addr  <= '0;
            r_wr_valid <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_alu_grant) begin
                r_prio <= 1'b1;
            end else if (w_mem_grant) begin
                r_prio <= 1'b0;
            end

            r_en       <= w_xfer ? w_dec : '0;
            r_wr_valid <= w_xfer & (|w_dec);
            if (w_xfer) begin
                r_wdata   <= w_sel_data;
                r_wr_addr <= w_sel_addr;
            end

            if (w_conflict && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign wb.alu_ready    = w_alu_grant;
    assign wb.mem_ready    = w_mem_grant;
    assign wb.rf_en        = r_en;
    assign wb.rf_wdata     = r_wdata;
    assign wb.rf_wr_addr   = r_wr_addr;
    assign wb.rf_wr_valid  = r_wr_valid;
    assign wb.conflict_cnt = r_cnt;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter.
// It drives hand-computed vectors through the writeback interface and checks grants, enables, data and the conflict counter.
module tb_rf_wb_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    rf_wb_arbiter_if #(.NREGS(32), .AW(5), .DW(32), .CNT_W(16)) bus ();

    rf_wb_arbiter #(.NREGS(32), .AW(5), .DW(32), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wb_stall  = 1'b0;
        bus.alu_valid = 1'b0;
        bus.alu_addr  = '0;
        bus.alu_data  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_data  = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();

        check_val("rst_rf_en",    bus.rf_en, 32'h0);
        check_val("rst_wdata",    bus.rf_wdata, 32'h0);
        check_val("rst_wr_addr",  32'(bus.rf_wr_addr), 32'h0);
        check_val("rst_wr_valid", 32'(bus.rf_wr_valid), 32'h0);
        check_val("rst_cnt",      32'(bus.conflict_cnt), 32'h0);
        rst = 1'b0;

        // Single ALU write to r5.
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
        #1;
        check_val("t1_alu_ready", 32'(bus.alu_ready), 32'h1);
        check_val("t1_mem_ready", 32'(bus.mem_ready), 32'h0);
        tick();
        bus.alu_valid = 1'b0;
        check_val("t1_rf_en",     bus.rf_en, 32'h0000_0020);
        check_val("t1_wdata",     bus.rf_wdata, 32'hDEAD_BEEF);
        check_val("t1_wr_addr",   32'(bus.rf_wr_addr), 32'h5);
        check_val("t1_wr_valid",  32'(bus.rf_wr_valid), 32'h1);
        tick();
        check_val("t1_idle_en",   bus.rf_en, 32'h0);
        check_val("t1_idle_hold", bus.rf_wdata, 32'hDEAD_BEEF);

        // A load to r0 completes the handshake but writes nothing. The grant also moves prio back to ALU.
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd0; bus.mem_data = 32'hFFFF_FFFF;
        #1;
        check_val("t3_mem_ready", 32'(bus.mem_ready), 32'h1);
        tick();
        bus.mem_valid = 1'b0;
        check_val("t3_rf_en",     bus.rf_en, 32'h0);
        check_val("t3_wr_valid",  32'(bus.rf_wr_valid), 32'h0);

        // Both sources are valid for 4 cycles, so the grants alternate ALU, MEM, ALU, MEM.
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 32'h1111_1111;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd7; bus.mem_data = 32'h7777_7777;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val($sformatf("t2_alu_ready_%0d", i), 32'(bus.alu_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
            check_val($sformatf("t2_mem_ready_%0d", i), 32'(bus.mem_ready), (i % 2 == 0) ? 32'h0 : 32'h1);
            tick();
            check_val($sformatf("t2_rf_en_%0d", i), bus.rf_en, (i % 2 == 0) ? 32'h8 : 32'h80);
            check_val($sformatf("t2_wdata_%0d", i), bus.rf_wdata, (i % 2 == 0) ? 32'h1111_1111 : 32'h7777_7777);
        end
        check_val("t2_cnt", 32'(bus.conflict_cnt), 32'd4);

        // While stalled, nothing is granted and the counter and prio stay frozen.
        bus.wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val($sformatf("t4_alu_ready_%0d", i), 32'(bus.alu_ready), 32'h0);
            check_val($sformatf("t4_mem_ready_%0d", i), 32'(bus.mem_ready), 32'h0);
            tick();
            check_val($sformatf("t4_rf_en_%0d", i), bus.rf_en, 32'h0);
        end
        check_val("t4_cnt_frozen", 32'(bus.conflict_cnt), 32'd4);
        bus.wb_stall = 1'b0;
        #1;
        check_val("t4_release_alu", 32'(bus.alu_ready), 32'h1);
        check_val("t4_release_mem", 32'(bus.mem_ready), 32'h0);
        tick();
        idle_inputs();
        check_val("t4_rf_en", bus.rf_en, 32'h8);
        check_val("t4_cnt", 32'(bus.conflict_cnt), 32'd5);

        // Both sources target the same address. Prio now favours MEM, so MEM is written first and the ALU write lands last.
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd9; bus.alu_data = 32'hAAAA_0001;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd9; bus.mem_data = 32'hBBBB_0002;
        #1;
        check_val("same_mem_first", 32'(bus.mem_ready), 32'h1);
        tick();
        bus.mem_valid = 1'b0;
        check_val("same_en_1",    bus.rf_en, 32'h200);
        check_val("same_data_1",  bus.rf_wdata, 32'hBBBB_0002);
        #1;
        check_val("same_alu_next", 32'(bus.alu_ready), 32'h1);
        tick();
        bus.alu_valid = 1'b0;
        check_val("same_en_2",    bus.rf_en, 32'h200);
        check_val("same_data_2",  bus.rf_wdata, 32'hAAAA_0001);
        check_val("same_cnt",     32'(bus.conflict_cnt), 32'd6);

        // Reset asserted mid-cycle must kill the pending write to r2 at once.
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd2; bus.alu_data = 32'h2222_2222;
        tick();
        bus.alu_valid = 1'b0;
        check_val("t5_rf_en_pre", bus.rf_en, 32'h4);
        #2;
        rst = 1'b1;
        #1;
        check_val("t5_rf_en_rst",  bus.rf_en, 32'h0);
        check_val("t5_valid_rst",  32'(bus.rf_wr_valid), 32'h0);
        check_val("t5_cnt_rst",    32'(bus.conflict_cnt), 32'h0);
        tick();
        rst = 1'b0;

        // Drive the counter to FFFE, then apply 3 more conflict cycles. It must saturate at FFFF.
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd1; bus.alu_data = 32'h1;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd4; bus.mem_data = 32'h4;
        for (int i = 0; i < 65534; i++) begin
            tick();
        end
        check_val("t6_cnt_fffe", 32'(bus.conflict_cnt), 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        check_val("t6_cnt_sat", 32'(bus.conflict_cnt), 32'h0000_FFFF);
        idle_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
